// File: rtl/simul_axi_ready_sched.sv
// simul_axi_ready_sched: per-channel ready-delay scheduler for AXI slow-ready generators,
// advancing a fixed/table/random/off delay source on every completed handshake.
module simul_axi_ready_sched #(
  parameter int NUM_CH = 4,
  parameter int TBL_DEPTH = 16,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_ch,
  input  logic [1:0]            cfg_sel,
  input  logic [3:0]            cfg_addr,
  input  logic [3:0]            cfg_data,
  input  logic [NUM_CH-1:0]     valid,
  input  logic [NUM_CH-1:0]     ready,
  output logic [4*NUM_CH-1:0]   delay,
  output logic [16*NUM_CH-1:0]  hs_cnt
);
  typedef enum logic {IDLE, WAIT} st_t;
  function automatic logic [3:0] src(input logic [1:0] m, input logic [3:0] v, input logic [3:0] e,
                                     input logic [15:0] l);
    return m == 2'd0 ? v : m == 2'd1 ? e : m == 2'd2 ? (l[3:0] & v) : 4'd0;
  endfunction
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [15:0] sx = SEED ^ 16'(c);
    localparam logic [15:0] seed = (sx == 16'h0) ? 16'h0001 : sx;
    st_t st, st_d;
    logic [1:0] mode, mode_d;
    logic [3:0] val, val_d, len, len_d, ptr, ptr_w, ptr_d, dly, dly_d, ent, ent_d;
    logic [3:0] tbl [TBL_DEPTH];
    logic [15:0] lfsr, lfsr_d, cnt;
    logic wr, hs, wr_mode, wr_tbl, adv;
    always_comb begin
      wr = cfg_we && cfg_ch == 3'(c);
      hs = valid[c] & ready[c];
      wr_mode = wr && cfg_sel == 2'd0;
      wr_tbl = wr && cfg_sel == 2'd3;
      mode_d = wr_mode ? cfg_data[1:0] : mode;
      val_d = (wr && cfg_sel == 2'd1) ? cfg_data : val;
      len_d = (wr && cfg_sel == 2'd2) ? cfg_data : len;
      ptr_w = (wr_mode || len_d < ptr) ? 4'd0 : ptr;
      // a mode write restarts the sequence and suppresses the advance on that edge
      adv = hs && !wr_mode;
      ptr_d = (adv && mode == 2'd1) ? ((ptr_w == len_d) ? 4'd0 : ptr_w + 4'd1) : ptr_w;
      lfsr_d = wr_mode ? seed :
               (adv && mode == 2'd2) ? {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]} : lfsr;
      ent = tbl[ptr];
      ent_d = (wr_tbl && cfg_addr == ptr_d) ? cfg_data : tbl[ptr_d];
      dly_d = hs ? src(mode_d, val_d, ent_d, lfsr_d) : (st == WAIT) ? dly : src(mode, val, ent, lfsr);
      st_d = (valid[c] && !ready[c]) ? WAIT : IDLE;
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        st <= IDLE;
        mode <= 2'd0;
        val <= 4'd0;
        len <= 4'd0;
        ptr <= 4'd0;
        lfsr <= seed;
        cnt <= 16'd0;
        dly <= 4'd0;
        for (int i = 0; i < TBL_DEPTH; i++) tbl[i] <= 4'd0;
      end else begin
        st <= st_d;
        mode <= mode_d;
        val <= val_d;
        len <= len_d;
        ptr <= ptr_d;
        lfsr <= lfsr_d;
        cnt <= cnt + 16'(hs);
        dly <= dly_d;
        if (wr_tbl) tbl[cfg_addr] <= cfg_data;
      end
    assign delay[4*c+:4] = dly;
    assign hs_cnt[16*c+:16] = cnt;
  end
endmodule

// File: tb/tb_simul_axi_ready_sched.sv
// tb_simul_axi_ready_sched: directed stimulus with a behavioural scheduler model checked every cycle,
// plus literal expectations for the documented sequences.
module tb_simul_axi_ready_sched;
  localparam int NCH = 4;
  logic clk = 0, reset = 1, cfg_we = 0;
  logic [2:0] cfg_ch = 0;
  logic [1:0] cfg_sel = 0;
  logic [3:0] cfg_addr = 0, cfg_data = 0;
  logic [NCH-1:0] valid = 0, ready = 0;
  logic [4*NCH-1:0] delay;
  logic [16*NCH-1:0] hs_cnt;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  simul_axi_ready_sched #(.NUM_CH(NCH), .TBL_DEPTH(16), .SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .valid(valid), .ready(ready),
    .delay(delay), .hs_cnt(hs_cnt));
  logic [1:0] m_mode [NCH];
  logic [3:0] m_val [NCH], m_len [NCH], m_ptr [NCH], m_dly [NCH];
  logic [3:0] m_tbl [NCH][16];
  logic [15:0] m_lfsr [NCH], m_cnt [NCH];
  logic m_wait [NCH];
  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
  function automatic logic [15:0] seed_of(input int c);
    logic [15:0] s;
    s = 16'hACE1 ^ 16'(c);
    return s == 0 ? 16'h0001 : s;
  endfunction
  function automatic logic [3:0] m_src(input int c);
    case (m_mode[c])
      2'd0: return m_val[c];
      2'd1: return m_tbl[c][m_ptr[c]];
      2'd2: return m_lfsr[c][3:0] & m_val[c];
      default: return 4'd0;
    endcase
  endfunction
  function automatic logic [3:0] dl(input int c);
    return delay[4*c+:4];
  endfunction
  function automatic logic [15:0] hc(input int c);
    return hs_cnt[16*c+:16];
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk or posedge reset) begin
    logic [3:0] shown;
    logic hs, wr;
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_mode[c] = 0; m_val[c] = 0; m_len[c] = 0; m_ptr[c] = 0; m_dly[c] = 0;
        m_lfsr[c] = seed_of(c); m_cnt[c] = 0; m_wait[c] = 0;
        for (int i = 0; i < 16; i++) m_tbl[c][i] = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        shown = m_src(c);
        hs = valid[c] && ready[c];
        wr = cfg_we && int'(cfg_ch) == c;
        if (wr)
          case (cfg_sel)
            2'd0: begin m_mode[c] = cfg_data[1:0]; m_ptr[c] = 0; m_lfsr[c] = seed_of(c); end
            2'd1: m_val[c] = cfg_data;
            2'd2: begin m_len[c] = cfg_data; if (m_ptr[c] > m_len[c]) m_ptr[c] = 0; end
            default: m_tbl[c][cfg_addr] = cfg_data;
          endcase
        if (hs) begin
          m_cnt[c]++;
          if (!(wr && cfg_sel == 2'd0)) begin
            if (m_mode[c] == 2'd1) m_ptr[c] = (m_ptr[c] == m_len[c]) ? 4'd0 : m_ptr[c] + 4'd1;
            else if (m_mode[c] == 2'd2) m_lfsr[c] = step(m_lfsr[c]);
          end
          m_dly[c] = m_src(c);
        end else if (!m_wait[c]) m_dly[c] = shown;
        m_wait[c] = valid[c] && !ready[c];
      end
    end
  end
  always @(negedge clk)
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("model_delay_ch%0d", c), 16'(dl(c)), 16'(m_dly[c]));
      chk($sformatf("model_hs_cnt_ch%0d", c), hc(c), m_cnt[c]);
    end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic cfg(input int ch, input int sel, input int addr, input int data);
    cfg_we = 1; cfg_ch = 3'(ch); cfg_sel = 2'(sel); cfg_addr = 4'(addr); cfg_data = 4'(data);
    tick();
    cfg_we = 0;
  endtask
  logic [3:0] seq [7];
  logic [3:0] exp_seq [7] = '{4'd3, 4'd0, 4'd7, 4'd3, 4'd0, 4'd7, 4'd3};
  initial begin
    tick(); tick();
    reset = 0;
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("reset_delay_ch%0d", c), 16'(dl(c)), 16'd0);
      chk($sformatf("reset_hs_cnt_ch%0d", c), hc(c), 16'd0);
    end
    // ch1 random with full mask exposes the seed: ACE0 -> 0, one step -> 59C1 -> 1
    cfg(1, 0, 0, 2); cfg(1, 1, 0, 15); tick();
    chk("ch1_seed_delay", 16'(dl(1)), 16'd0);
    valid[1] = 1; ready[1] = 1; tick(); valid[1] = 0; ready[1] = 0;
    chk("ch1_lfsr_step_delay", 16'(dl(1)), 16'd1);
    cfg(0, 0, 0, 1); cfg(0, 2, 0, 2); cfg(0, 3, 0, 3); cfg(0, 3, 1, 0); cfg(0, 3, 2, 7); tick();
    for (int i = 0; i < 7; i++) begin
      valid[0] = 1; ready[0] = 1; seq[i] = dl(0); tick();
    end
    valid[0] = 0; ready[0] = 0;
    for (int i = 0; i < 7; i++) chk($sformatf("ch0_table_seq%0d", i), 16'(seq[i]), 16'(exp_seq[i]));
    chk("ch0_hs_cnt", hc(0), 16'd7);
    cfg(1, 0, 0, 0); cfg(1, 1, 0, 5); tick();
    chk("ch1_fixed5", 16'(dl(1)), 16'd5);
    valid[1] = 1; tick();
    cfg(1, 1, 0, 9); tick();
    chk("ch1_frozen_in_wait", 16'(dl(1)), 16'd5);
    ready[1] = 1; tick(); valid[1] = 0; ready[1] = 0;
    chk("ch1_after_hs", 16'(dl(1)), 16'd9);
    cfg(2, 0, 0, 2); cfg(2, 1, 0, 3); tick();
    chk("ch2_seed_delay", 16'(dl(2)), 16'd3);
    for (int i = 0; i < 100; i++) begin
      valid[2] = 1; ready[2] = 1;
      checks++;
      if (dl(2) > 4'd3) begin fails++; $display("FAIL ch2_mask: got %0d, required <= 3", dl(2)); end
      tick();
    end
    valid[2] = 0; ready[2] = 0;
    chk("ch2_hs_cnt", hc(2), 16'd100);
    cfg(5, 0, 0, 3);
    cfg(3, 0, 0, 1); cfg(3, 2, 0, 5);
    for (int i = 0; i < 6; i++) cfg(3, 3, i, 10 + i);
    tick();
    valid[3] = 1; ready[3] = 1; tick(); tick(); tick(); valid[3] = 0; ready[3] = 0;
    chk("ch3_ptr3", 16'(dl(3)), 16'd13);
    cfg(3, 2, 0, 1); tick();
    chk("ch3_len_shrink", 16'(dl(3)), 16'd10);
    valid[3] = 1; ready[3] = 1; cfg(3, 0, 0, 1);
    valid[3] = 0; ready[3] = 0;
    chk("ch3_mode_hs_no_adv", 16'(dl(3)), 16'd10);
    valid[3] = 1; ready[3] = 1; tick(); valid[3] = 0; ready[3] = 0;
    chk("ch3_adv", 16'(dl(3)), 16'd11);
    valid = '1; ready = '0; tick(); tick();
    #1 reset = 1;
    #1;
    for (int c = 0; c < NCH; c++) chk($sformatf("wait_reset_delay_ch%0d", c), 16'(dl(c)), 16'd0);
    tick();
    reset = 0; valid = '0;
    tick();
    valid[0] = 1; ready[0] = 1; tick(); valid[0] = 0; ready[0] = 0;
    chk("post_reset_hs", hc(0), 16'd1);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/simul_axi_ready_sched.md
# simul_axi_ready_sched

Simulation-only scheduler that configures the ready-delay of up to NUM_CH AXI slow-ready generators, one per simulated channel (AW, W, AR, B, …). For every channel it produces a 4-bit delay value and advances it on each completed handshake, following a per-channel mode:
- fixed,
- programmable table,
- pseudo-random,
- off.

It sits in the testbench between the bench control tasks and the slow-ready instances. This lets directed tests apply reproducible back-pressure patterns without re-editing the bench.

## Interface
Parameters:
- NUM_CH, 4, number of scheduled channels (1..8)
- TBL_DEPTH, 16, table entries per channel (fixed at 16, 4-bit index)
- SEED, 16'hACE1, base LFSR seed; channel c uses SEED ^ c (forced to 16'h0001 if the result is zero)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- cfg_we  input  1  configuration write strobe, one cycle per write
- cfg_ch  input  3  target channel; writes with cfg_ch ≥ NUM_CH are ignored
- cfg_sel  input  2  register select: 0 mode, 1 value/mask, 2 table length, 3 table entry
- cfg_addr  input  4  table index (cfg_sel=3 only)
- cfg_data  input  4  write data (mode uses [1:0])
- valid  input  NUM_CH  per-channel valid, as seen by the slow-ready generator
- ready  input  NUM_CH  per-channel ready returned by the slow-ready generator
- delay  output  4*NUM_CH  per-channel delay to the generators; channel c occupies [4c+3:4c]
- hs_cnt  output  16*NUM_CH  per-channel handshake count; wraps at 16'hFFFF→0

## Operation
- Handshake on channel c: valid[c] & ready[c] sampled at posedge clk.
- Per-channel registers:
  - mode[1:0]: 0 fixed, 1 table, 2 random, 3 off
  - val[3:0]: the fixed value, or the random mask
  - len[3:0]: table holds entries 0..len, so len=0 means one entry
  - tbl[16][3:0]: table entries
  - ptr[3:0]: table pointer
  - lfsr[15:0]: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left, feedback into bit 0
- Delay source per mode:
  - fixed → val
  - table → tbl[ptr]
  - random → lfsr[3:0] & val
  - off → 0
- Per-channel state machine:
  - IDLE: valid[c]=0. Delay output tracks config changes, updated on the edge after a write.
  - WAIT: valid[c]=1 & ready[c]=0. Delay output is frozen; config writes are stored but not applied to delay.
  - Transitions: IDLE→WAIT when valid & !ready; WAIT→IDLE on handshake or when valid drops.
- On handshake:
  - hs_cnt increments.
  - Table mode: ptr ← (ptr==len) ? 0 : ptr+1.
  - Random mode: lfsr steps once.
  - The new delay is registered from the advanced state.
- Handshakes in IDLE (ready already high, e.g. delay 0) advance the state identically.
- Mode write: ptr ← 0 and lfsr ← channel seed, regardless of the old mode.
- Writing len below the current ptr: ptr ← 0 at the same edge.
- Simultaneous config write and handshake on the same channel:
  - The write is applied first, then the advance rule.
  - Exception: a mode write resets ptr/lfsr with no advance on that edge.
- Writes to a table entry other than the current one never change delay.
- Reset clears:
  - all delay, hs_cnt, ptr, val, len and tbl to 0
  - mode to 0 (fixed)
  - lfsr to the channel seed
- Reset asserted mid-transfer returns every channel to IDLE with delay 0.

## Timing
- Handshake at edge t → delay for the next transfer is valid after edge t (one register stage). It is therefore stable before the generator's next valid.
- Config write at edge t on an IDLE channel → delay updated after edge t+1.
- In WAIT, the delay output does not change until the channel leaves WAIT; a pending config then appears one edge later.
- hs_cnt updates at the handshake edge, with no extra latency.
- No combinational path from any input to any output.

## Test plan
- Reset with all valid=0 → delay=0 and hs_cnt=0 on every channel; the lfsr of ch1 equals 16'hACE0 (checked through random mode with val=4'hF).
- Ch0 table mode, len=2, tbl={3,0,7}, then 7 back-to-back transfers → delay sequence 3,0,7,3,0,7,3; hs_cnt=7.
- Ch1 fixed val=5, then write val=9 while in WAIT → delay stays 5 until the handshake, then becomes 9 for the next transfer.
- Ch2 random mode, mask=4'h3, 100 transfers → every delay ≤ 3; the sequence matches the software LFSR model from seed 16'hACE3.
- Ch3 table mode, ptr=3, then write len=1 → ptr=0 and delay=tbl[0]. A simultaneous handshake and mode write → ptr=0 with no advance.
- Assert reset during WAIT on all channels → delay=0 after reset; the next transfer completes immediately (ready=1 at generator delay 0).
